rect_draw_scheduler: RTL and testbench

//  Shares the single VGA adapter plot port (x, y, colour, plot) between N_REQ drawing requesters:

---
 rtl/rect_draw_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_rect_draw_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_scheduler.sv
// Round-robin arbiter that lets N_REQ requesters share one VGA plot port.
// Each grant draws one clipped solid rectangle, one pixel per clock, in raster order.
module rect_draw_scheduler #(
  parameter int N_REQ    = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*X_W-1:0]       req_x,
  input  logic [N_REQ*Y_W-1:0]       req_y,
  input  logic [N_REQ*X_W-1:0]       req_w,
  input  logic [N_REQ*Y_W-1:0]       req_h,
  input  logic [N_REQ*COLOR_W-1:0]   req_color,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic                       plot,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOR_W-1:0]         vga_color
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [X_W-1:0]       x_q, x_d, w_q, w_d, dx_q, dx_d;
  logic [Y_W-1:0]       y_q, y_d, h_q, h_d, dy_q, dy_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [IDX_W-1:0]     winner_q, winner_d, rr_q, rr_d;
  logic [N_REQ-1:0]     grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]       vgaX_q, vgaX_d;
  logic [Y_W-1:0]       vgaY_q, vgaY_d;
  logic [COLOR_W-1:0]   vgaColor_q, vgaColor_d;

  logic [X_W-1:0]       reqX [N_REQ];
  logic [Y_W-1:0]       reqY [N_REQ];
  logic [X_W-1:0]       reqW [N_REQ];
  logic [Y_W-1:0]       reqH [N_REQ];
  logic [COLOR_W-1:0]   reqC [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign reqX[g] = req_x[g*X_W +: X_W];
    assign reqY[g] = req_y[g*Y_W +: Y_W];
    assign reqW[g] = req_w[g*X_W +: X_W];
    assign reqH[g] = req_h[g*Y_W +: Y_W];
    assign reqC[g] = req_color[g*COLOR_W +: COLOR_W];
  end

  // First requesting index at or above the rr pointer, wrapping around.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  logic           lastCol, lastRow;
  logic [X_W:0]   sumX;
  logic [Y_W:0]   sumY;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    winner_d   = winner_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    done_d     = '0;
    plot_d     = 1'b0;
    vgaX_d     = vgaX_q;
    vgaY_d     = vgaY_q;
    vgaColor_d = vgaColor_q;
    lastCol    = (dx_q == w_q - X_W'(1));
    lastRow    = (dy_q == h_q - Y_W'(1));

    case (state_q)
      IDLE: begin
        if (found) begin
          x_d      = reqX[pick];
          y_d      = reqY[pick];
          w_d      = reqW[pick];
          h_d      = reqH[pick];
          color_d  = reqC[pick];
          winner_d = pick;
          dx_d     = '0;
          dy_d     = '0;
          grant_d  = '0;
          if (reqW[pick] == '0 || reqH[pick] == '0) begin
            state_d      = DONE;
            done_d[pick] = 1'b1;
          end else begin
            state_d       = DRAW;
            grant_d[pick] = 1'b1;
          end
        end
      end
      DRAW: begin
        if (lastCol && lastRow) begin
          state_d          = DONE;
          grant_d          = '0;
          done_d[winner_q] = 1'b1;
        end else if (lastCol) begin
          dx_d = '0;
          dy_d = dy_q + Y_W'(1);
        end else begin
          dx_d = dx_q + X_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = (winner_q == IDX_W'(N_REQ-1)) ? '0 : winner_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Pixel outputs are registered, so they describe the pixel of the next cycle.
    sumX = {1'b0, x_d} + {1'b0, dx_d};
    sumY = {1'b0, y_d} + {1'b0, dy_d};
    if (state_d == DRAW) begin
      plot_d     = (sumX < SCR_W) && (sumY < SCR_H);
      vgaX_d     = sumX[X_W-1:0];
      vgaY_d     = sumY[Y_W-1:0];
      vgaColor_d = color_d;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      winner_q   <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      plot_q     <= 1'b0;
      vgaX_q     <= '0;
      vgaY_q     <= '0;
      vgaColor_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      winner_q   <= winner_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      plot_q     <= plot_d;
      vgaX_q     <= vgaX_d;
      vgaY_q     <= vgaY_d;
      vgaColor_q <= vgaColor_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign plot      = plot_q;
  assign vga_x     = vgaX_q;
  assign vga_y     = vgaY_q;
  assign vga_color = vgaColor_q;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Bench for rect_draw_scheduler: directed literal scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the expected output trace.
module tb_rect_draw_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    reqR;
  logic [XW-1:0]   px [N];
  logic [YW-1:0]   py [N];
  logic [XW-1:0]   pw [N];
  logic [YW-1:0]   ph [N];
  logic [CW-1:0]   pc [N];
  logic [N*XW-1:0] reqXBus, reqWBus;
  logic [N*YW-1:0] reqYBus, reqHBus;
  logic [N*CW-1:0] reqCBus;

  logic [N-1:0]  grant, done;
  logic          busy, plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_color;

  int  assertCount = 0;
  int  failCount   = 0;
  bit  stopping    = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign reqXBus[g*XW +: XW] = px[g];
    assign reqYBus[g*YW +: YW] = py[g];
    assign reqWBus[g*XW +: XW] = pw[g];
    assign reqHBus[g*YW +: YW] = ph[g];
    assign reqCBus[g*CW +: CW] = pc[g];
  end

  rect_draw_scheduler #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .req(reqR),
    .req_x(reqXBus), .req_y(reqYBus), .req_w(reqWBus), .req_h(reqHBus), .req_color(reqCBus),
    .grant(grant), .done(done), .busy(busy), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One entry per expected output cycle after an acceptance: pixels, then the done cycle.
  typedef struct {
    bit isPix;
    bit plot;
    int x;
    int y;
    int c;
    int grant;
    int done;
  } exp_t;

  exp_t expQ[$];
  int   modelRr = 0;

  function automatic void modelAccept();
    int         win = -1;
    logic [1:0] wk;
    int         x, y, w, h, c;
    exp_t       e;
    for (int k = 0; k < N; k++) begin
      logic [1:0] idx;
      idx = 2'((modelRr + k) % N);
      if (win < 0 && reqR[idx]) win = int'(idx);
    end
    wk = 2'(win);
    x = int'(px[wk]); y = int'(py[wk]); w = int'(pw[wk]); h = int'(ph[wk]); c = int'(pc[wk]);
    if (w > 0 && h > 0) begin
      for (int dy = 0; dy < h; dy++) begin
        for (int dx = 0; dx < w; dx++) begin
          e.isPix = 1'b1;
          e.plot  = (x + dx < SW) && (y + dy < SH);
          e.x     = (x + dx) % (1 << XW);
          e.y     = (y + dy) % (1 << YW);
          e.c     = c;
          e.grant = 1 << win;
          e.done  = 0;
          expQ.push_back(e);
        end
      end
    end
    e.isPix = 1'b0; e.plot = 1'b0; e.x = 0; e.y = 0; e.c = 0; e.grant = 0; e.done = 1 << win;
    expQ.push_back(e);
    modelRr = (win + 1) % N;
  endfunction

  // Compares every cycle against the model; an empty queue means the scheduler should be idle.
  always @(negedge clk) begin : compareProc
    exp_t e;
    if (reset) begin
      expQ.delete();
      modelRr = 0;
      checkOutput("rstOutputs", 32'({grant, done, busy, plot}), 0);
    end else if (expQ.size() == 0) begin
      checkOutput("idleGrant", 32'(grant), 0);
      checkOutput("idleDone",  32'(done),  0);
      checkOutput("idleBusy",  32'(busy),  0);
      checkOutput("idlePlot",  32'(plot),  0);
      if (reqR != '0) modelAccept();
    end else begin
      e = expQ.pop_front();
      checkOutput("mdlGrant", 32'(grant), e.grant);
      checkOutput("mdlDone",  32'(done),  e.done);
      checkOutput("mdlBusy",  32'(busy),  1);
      checkOutput("mdlPlot",  32'(plot),  32'(e.plot));
      if (e.isPix) begin
        checkOutput("mdlX",     32'(vga_x),     e.x);
        checkOutput("mdlY",     32'(vga_y),     e.y);
        checkOutput("mdlColor", 32'(vga_color), e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input int x, input int y,
                               input int w, input int h, input int c);
    px[idx] = XW'(x); py[idx] = YW'(y); pw[idx] = XW'(w); ph[idx] = YW'(h); pc[idx] = CW'(c);
    reqR[idx] = 1'b1;
  endtask

  task automatic waitDone(input logic [1:0] idx, input int maxCycles);
    bit seen = 1'b0;
    for (int n = 0; n < maxCycles && !seen; n++) begin
      tick();
      if (done[idx]) seen = 1'b1;
    end
    if (!seen) checkOutput("waitDoneTimeout", 0, 1);
  endtask

  task automatic randParams(input logic [1:0] k);
    pw[k] = ($urandom_range(7) == 0) ? '0 : XW'($urandom_range(1, 6));
    ph[k] = ($urandom_range(7) == 0) ? '0 : YW'($urandom_range(1, 4));
    px[k] = ($urandom_range(1) == 1) ? XW'($urandom_range(0, 255)) : XW'($urandom_range(150, 165));
    py[k] = ($urandom_range(1) == 1) ? YW'($urandom_range(0, 127)) : YW'($urandom_range(112, 125));
    pc[k] = CW'($urandom_range(7));
  endtask

  // Requesters hold req and parameters until done; parameters only scramble while granted.
  task automatic driveRandom();
    for (int i = 0; i < N; i++) begin
      logic [1:0] k;
      k = 2'(i);
      if (reqR[k]) begin
        if (done[k]) begin
          if (!stopping && $urandom_range(1) == 1) randParams(k);
          else reqR[k] = 1'b0;
        end else if (grant[k] && $urandom_range(3) == 0) begin
          randParams(k);
        end
      end else if (!stopping && $urandom_range(3) == 0) begin
        randParams(k);
        reqR[k] = 1'b1;
      end
    end
  endtask

  initial begin
    int gi, di, plots, lastX, lastY, doneAt;
    reqR  = '0;
    for (int i = 0; i < N; i++) begin
      logic [1:0] k;
      k = 2'(i);
      px[k] = '0; py[k] = '0; pw[k] = '0; ph[k] = '0; pc[k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Two 1x1 requesters held together must alternate starting from requester 0.
    applyStimulus(2'd0, 1, 1, 1, 1, 2);
    applyStimulus(2'd2, 3, 3, 1, 1, 7);
    gi = 0; di = 0;
    for (int n = 0; n < 40 && di < 4; n++) begin
      @(negedge clk);
      checkOutput("t2OneHot", 32'($countones(grant) <= 1), 1);
      if (grant != '0 && gi < 4) begin
        checkOutput("t2GrantOrder", 32'(grant), (gi % 2 == 0) ? 1 : 4);
        gi++;
      end
      if (done != '0 && di < 4) begin
        checkOutput("t2DoneOrder", 32'(done), (di % 2 == 0) ? 1 : 4);
        di++;
      end
    end
    checkOutput("t2DoneCount", di, 4);
    @(posedge clk); #1;
    reqR[0] = 1'b0; reqR[2] = 1'b0;
    tick();

    // 3x2 rectangle at (10,20) colour 5 from requester 1.
    applyStimulus(2'd1, 10, 20, 3, 2, 5);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checkOutput("t1Plot",  32'(plot), 1);
        checkOutput("t1X",     32'(vga_x), 10 + c);
        checkOutput("t1Y",     32'(vga_y), 20 + r);
        checkOutput("t1Color", 32'(vga_color), 5);
        checkOutput("t1Grant", 32'(grant), 2);
      end
    end
    @(negedge clk);
    checkOutput("t1Done",      32'(done), 2);
    checkOutput("t1GrantDone", 32'(grant), 0);
    @(posedge clk); #1;
    reqR[1] = 1'b0;
    tick();

    // Right-edge clipping: columns 160 and 161 keep their cycle but do not plot.
    applyStimulus(2'd3, 158, 10, 4, 2, 3);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checkOutput("t3X",    32'(vga_x), 158 + c);
        checkOutput("t3Plot", 32'(plot), (c < 2) ? 1 : 0);
      end
    end
    @(negedge clk);
    checkOutput("t3Done", 32'(done), 8);
    @(posedge clk); #1;
    reqR[3] = 1'b0;
    tick();

    // Full-screen clear.
    applyStimulus(2'd0, 0, 0, 160, 120, 0);
    @(negedge clk);
    plots = 0; lastX = -1; lastY = -1; doneAt = 0;
    for (int n = 1; n <= 19300 && doneAt == 0; n++) begin
      @(negedge clk);
      if (plot) begin
        plots++;
        lastX = int'(vga_x);
        lastY = int'(vga_y);
      end
      if (done[0]) doneAt = n;
    end
    checkOutput("t5Plots",  plots,  19200);
    checkOutput("t5LastX",  lastX,  159);
    checkOutput("t5LastY",  lastY,  119);
    checkOutput("t5DoneAt", doneAt, 19201);
    @(posedge clk); #1;
    reqR[0] = 1'b0;
    tick();

    // Zero-width rectangle goes straight to done.
    applyStimulus(2'd2, 40, 40, 0, 5, 1);
    @(negedge clk);
    checkOutput("t4BusyAccept", 32'(busy), 0);
    @(negedge clk);
    checkOutput("t4Done", 32'(done), 4);
    checkOutput("t4Busy", 32'(busy), 1);
    checkOutput("t4Plot", 32'(plot), 0);
    @(posedge clk); #1;
    reqR[2] = 1'b0;
    @(negedge clk);
    checkOutput("t4BusyOff", 32'(busy), 0);
    tick();

    // Asynchronous reset mid-draw, then re-arbitration from pointer 0.
    applyStimulus(2'd3, 30, 30, 20, 20, 4);
    applyStimulus(2'd1, 5, 5, 2, 2, 6);
    repeat (10) @(negedge clk);
    checkOutput("t6GrantPre", 32'(grant), 8);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6RstPlot",  32'(plot),  0);
    checkOutput("t6RstGrant", 32'(grant), 0);
    checkOutput("t6RstDone",  32'(done),  0);
    checkOutput("t6RstBusy",  32'(busy),  0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("t6Winner", 32'(grant), 2);
    reqR[3] = 1'b0;
    waitDone(2'd1, 20);
    reqR[1] = 1'b0;
    tick();

    repeat (4000) begin
      tick();
      driveRandom();
    end
    stopping = 1'b1;
    for (int n = 0; n < 3000 && reqR != '0; n++) begin
      tick();
      driveRandom();
    end
    checkOutput("drainReq", 32'(reqR), 0);
    repeat (3) tick();
    checkOutput("finalIdle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
